// File: rtl/pgs_tsmac_rx_frame_buf.sv
// Receive frame buffer: stores MAC receive bytes, commits or drops whole frames
// on the status strobe, and replays committed frames over a valid/ready stream.
module pgs_tsmac_rx_frame_buf #(
    parameter int ADDR_W    = 11,
    parameter int DESC_W    = 4,
    parameter int CNT_W     = 32,
    parameter int STRIP_FCS = 0
) (
    input  logic              rx_clk,
    input  logic              srrfn,
    input  logic              clk_en,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic              in_eof,
    input  logic              stat_valid,
    input  logic [32:0]       stat_vec,
    input  logic              addr_drop,
    output logic [7:0]        out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic [32:0]       out_stat,
    output logic [CNT_W-1:0]  cnt_good,
    output logic [CNT_W-1:0]  cnt_err_drop,
    output logic [CNT_W-1:0]  cnt_ovf_drop,
    output logic [CNT_W-1:0]  cnt_pause,
    output logic [ADDR_W:0]   buf_free
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int DDEPTH = 1 << DESC_W;
    localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] FCS  = (ADDR_W+1)'(4);
    localparam logic [ADDR_W:0] SKIP =
        (STRIP_FCS != 0) ? (ADDR_W+1)'(5) : (ADDR_W+1)'(1);
    localparam logic [DESC_W:0] DONE = (DESC_W+1)'(1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

    logic [7:0]        r_mem   [DEPTH];
    logic [ADDR_W:0]   r_dlen  [DDEPTH];
    logic [32:0]       r_dstat [DDEPTH];

    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_frm_start;
    logic [ADDR_W:0]   r_len;
    logic              r_in_frm;
    logic              r_rx_act;
    logic              r_ovf;
    logic [DESC_W:0]   r_dwr;
    logic [DESC_W:0]   r_drd;
    logic [ADDR_W:0]   r_rd_ptr;
    logic [ADDR_W:0]   r_left;
    logic [7:0]        r_rdata;
    logic [32:0]       r_stat;
    logic [CNT_W-1:0]  r_cnt_good;
    logic [CNT_W-1:0]  r_cnt_err;
    logic [CNT_W-1:0]  r_cnt_ovf;
    logic [CNT_W-1:0]  r_cnt_pause;
    state_t            r_state;
    state_t            w_state_nx;

    logic              w_sv;
    logic              w_dfull;
    logic              w_dempty;
    logic              w_len_ok;
    logic [ADDR_W:0]   w_dlen;
    logic              w_err;
    logic              w_commit;
    logic              w_sof;
    logic              w_abort;
    logic              w_rewind;
    logic [ADDR_W:0]   w_wbase;
    logic [ADDR_W:0]   w_free_eff;
    logic              w_byte;
    logic              w_ovf_cur;
    logic              w_wr;
    logic              w_ovf_set;
    logic              w_fire;
    logic              w_last;
    logic [ADDR_W:0]   w_raddr;
    logic [DESC_W-1:0] w_drd_idx;

    // Status only counts for a frame that was opened by an accepted in_sof
    assign w_sv      = clk_en & stat_valid & r_in_frm;
    assign w_dfull   = (r_dwr - r_drd) == (DESC_W+1)'(DDEPTH);
    assign w_dempty  = (r_dwr == r_drd);
    assign w_len_ok  = (STRIP_FCS != 0) ? (r_len > FCS) : (r_len != '0);
    assign w_dlen    = (STRIP_FCS != 0) ? (r_len - FCS) : r_len;
    assign w_err     = stat_vec[20] | stat_vec[21] | addr_drop;
    assign w_commit  = w_sv & ~w_err & ~stat_vec[28] & ~r_ovf
                     & ~w_dfull & w_len_ok;

    assign w_sof     = clk_en & in_valid & in_sof;
    assign w_abort   = w_sof & r_in_frm & ~w_sv;
    assign w_rewind  = (w_sv & ~w_commit) | w_abort;
    assign w_wbase   = w_rewind ? r_frm_start : r_wr_ptr;
    assign w_free_eff = (ADDR_W+1)'(DEPTH) - (w_wbase - r_rd_ptr);

    assign w_byte    = clk_en & in_valid & (in_sof | r_rx_act);
    assign w_ovf_cur = w_sof ? 1'b0 : r_ovf;
    assign w_wr      = w_byte & ~w_ovf_cur & (w_free_eff != '0);
    assign w_ovf_set = w_byte & ~w_ovf_cur & (w_free_eff == '0);

    assign buf_free  = (ADDR_W+1)'(DEPTH) - (r_wr_ptr - r_rd_ptr);

    always_ff @(posedge rx_clk) begin
        if (srrfn && w_wr) begin
            r_mem[w_wbase[ADDR_W-1:0]] <= in_data;
        end
    end

    always_ff @(posedge rx_clk) begin
        if (srrfn && w_commit) begin
            r_dlen[r_dwr[DESC_W-1:0]]  <= w_dlen;
            r_dstat[r_dwr[DESC_W-1:0]] <= stat_vec;
        end
    end

    always_ff @(posedge rx_clk) begin
        if (!srrfn) begin
            r_wr_ptr    <= '0;
            r_frm_start <= '0;
            r_len       <= '0;
            r_in_frm    <= 1'b0;
            r_rx_act    <= 1'b0;
            r_ovf       <= 1'b0;
            r_dwr       <= '0;
        end else if (clk_en) begin
            r_wr_ptr <= w_wbase + (ADDR_W+1)'(w_wr);
            if (w_commit) begin
                r_dwr <= r_dwr + DONE;
            end
            if (w_sof) begin
                r_frm_start <= w_wbase;
                r_len       <= (ADDR_W+1)'(w_wr);
                r_ovf       <= w_ovf_set;
                r_in_frm    <= 1'b1;
                r_rx_act    <= ~in_eof;
            end else begin
                if (w_byte) begin
                    r_len <= r_len + (ADDR_W+1)'(w_wr);
                    r_ovf <= r_ovf | w_ovf_set;
                    if (in_eof) begin
                        r_rx_act <= 1'b0;
                    end
                end
                if (w_sv) begin
                    r_in_frm <= 1'b0;
                    r_rx_act <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge rx_clk) begin
        if (!srrfn) begin
            r_cnt_good  <= '0;
            r_cnt_err   <= '0;
            r_cnt_ovf   <= '0;
            r_cnt_pause <= '0;
        end else begin
            if (w_commit && r_cnt_good != '1) begin
                r_cnt_good <= r_cnt_good + CNT_W'(1);
            end
            if (w_sv && w_err && r_cnt_err != '1) begin
                r_cnt_err <= r_cnt_err + CNT_W'(1);
            end
            if (w_sv && (r_ovf || w_dfull) && r_cnt_ovf != '1) begin
                r_cnt_ovf <= r_cnt_ovf + CNT_W'(1);
            end
            if (w_sv && stat_vec[28] && r_cnt_pause != '1) begin
                r_cnt_pause <= r_cnt_pause + CNT_W'(1);
            end
        end
    end

    assign cnt_good     = r_cnt_good;
    assign cnt_err_drop = r_cnt_err;
    assign cnt_ovf_drop = r_cnt_ovf;
    assign cnt_pause    = r_cnt_pause;

    // Read address runs one byte ahead on a handshake so data keeps pace
    assign w_fire    = clk_en & (r_state == SEND) & out_ready;
    assign w_last    = (r_left == ONE);
    assign w_raddr   = w_fire ? (r_rd_ptr + ONE) : r_rd_ptr;
    assign w_drd_idx = r_drd[DESC_W-1:0];

    always_ff @(posedge rx_clk) begin
        if (!srrfn) begin
            r_state <= IDLE;
        end else if (clk_en) begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_dempty) begin
                    w_state_nx = LOAD;
                end
            end
            LOAD: begin
                w_state_nx = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                out_last  = w_last;
                if (out_ready && w_last) begin
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge rx_clk) begin
        if (!srrfn) begin
            r_rd_ptr <= '0;
            r_drd    <= '0;
            r_left   <= '0;
            r_stat   <= '0;
            r_rdata  <= '0;
        end else if (clk_en) begin
            if (r_state != IDLE) begin
                r_rdata <= r_mem[w_raddr[ADDR_W-1:0]];
            end
            if (r_state == LOAD) begin
                r_left <= r_dlen[w_drd_idx];
                r_stat <= r_dstat[w_drd_idx];
                r_drd  <= r_drd + DONE;
            end
            // Final handshake also releases any stripped FCS bytes
            if (w_fire) begin
                r_left   <= r_left - ONE;
                r_rd_ptr <= r_rd_ptr + (w_last ? SKIP : ONE);
            end
        end
    end

    assign out_data = r_rdata;
    assign out_stat = r_stat;

endmodule
